// File: rtl/pushbutton_bank_pkg.sv
// Shared definitions for the pushbutton bank: counter width helper and the
// level/pulse encodings used by every channel.
package pushbutton_bank_pkg;

   // Level encoding of the debounced outputs.
   localparam logic LEVEL_PRESSED  = 1'b1;
   localparam logic LEVEL_RELEASED = 1'b0;

   // Encoding of the single-cycle event outputs.
   localparam logic PULSE_ON  = 1'b1;
   localparam logic PULSE_OFF = 1'b0;

   // Counter width for a terminal value; never returns less than one bit so
   // that degenerate parameters still produce a legal vector.
   function automatic int cnt_width(input int value);
      if (value <= 1) begin
         return 1;
      end
      return $clog2(value);
   endfunction

endpackage

// File: rtl/pushbutton_channel.sv
// One debounced button channel: 2-flop synchroniser, debounce counter,
// press/release pulses, toggle level and (with PUSHBUTTON_BANK_LONGPRESS_EN
// defined) a saturating hold counter that fires one long-press pulse.
module pushbutton_channel
   import pushbutton_bank_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES  = 240000,
`ifdef PUSHBUTTON_BANK_LONGPRESS_EN
   parameter int LONGPRESS_CYCLES = 48000000,
`endif
   parameter bit INVERT           = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic cg_i,
   input  logic button_i,
   output logic debounced_o,
   output logic toggle_o,
   output logic pressed_o,
   output logic released_o,
   output logic longpress_o
);

   localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] db_cnt_q, db_cnt_d;
   logic          deb_q, deb_d;
   logic          tog_q, tog_d;
   logic          pressed_q, pressed_d;
   logic          released_q, released_d;
   logic          differ, flip, rise, fall;

   // Synchroniser runs every cycle so the pin is always freshly sampled,
   // regardless of the clock-gate enable.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= button_i ^ INVERT;
         sync2_q <= sync1_q;
      end
   end

   // Debounce counter, accepted level and event decode; all hold while gated.
   always_comb begin
      db_cnt_d   = db_cnt_q;
      deb_d      = deb_q;
      differ     = (sync2_q != deb_q);
      flip       = cg_i && differ && (db_cnt_q == DB_LAST);
      rise       = flip && (deb_q == LEVEL_RELEASED);
      fall       = flip && (deb_q == LEVEL_PRESSED);
      tog_d      = tog_q ^ rise;
      pressed_d  = rise ? PULSE_ON : PULSE_OFF;
      released_d = fall ? PULSE_ON : PULSE_OFF;
      if (cg_i) begin
         if (!differ) begin
            db_cnt_d = '0;
         end else if (db_cnt_q == DB_LAST) begin
            db_cnt_d = '0;
            deb_d    = ~deb_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   // Debounce state and event registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         db_cnt_q   <= '0;
         deb_q      <= LEVEL_RELEASED;
         tog_q      <= 1'b0;
         pressed_q  <= PULSE_OFF;
         released_q <= PULSE_OFF;
      end else begin
         db_cnt_q   <= db_cnt_d;
         deb_q      <= deb_d;
         tog_q      <= tog_d;
         pressed_q  <= pressed_d;
         released_q <= released_d;
      end
   end

   assign debounced_o = deb_q;
   assign toggle_o    = tog_q;
   // Pulses are masked by the enable so nothing is reported while gated.
   assign pressed_o   = pressed_q  & cg_i;
   assign released_o  = released_q & cg_i;

`ifdef PUSHBUTTON_BANK_LONGPRESS_EN
   localparam int            HW        = cnt_width(LONGPRESS_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONGPRESS_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONGPRESS_CYCLES);

   logic [HW-1:0] hold_q, hold_d;
   logic          lp_q, lp_d;

   // Hold counter: counts pressed cycles, fires once on reaching the limit,
   // then saturates until the accepted level falls.
   always_comb begin
      hold_d = hold_q;
      lp_d   = PULSE_OFF;
      if (cg_i) begin
         if (fall) begin
            hold_d = '0;
         end else if ((deb_q == LEVEL_PRESSED) && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
            lp_d   = (hold_q == HOLD_LAST) ? PULSE_ON : PULSE_OFF;
         end
      end
   end

   // Hold counter and long-press pulse registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_q <= '0;
         lp_q   <= PULSE_OFF;
      end else begin
         hold_q <= hold_d;
         lp_q   <= lp_d;
      end
   end

   assign longpress_o = lp_q & cg_i;
`else
   assign longpress_o = PULSE_OFF;
`endif

endmodule

// File: rtl/pushbutton_bank.sv
// Bank of N_BUTTON independent debounced pushbuttons. Each channel is a
// pushbutton_channel instance. Define PUSHBUTTON_BANK_LONGPRESS_EN to add
// per-channel long-press detection; otherwise o_longpress is tied low.
module pushbutton_bank
   import pushbutton_bank_pkg::*;
#(
   parameter int                  N_BUTTON         = 4,
   parameter int                  DEBOUNCE_CYCLES  = 240000,
   parameter int                  LONGPRESS_CYCLES = 48000000,
   parameter logic [N_BUTTON-1:0] ACTIVE_LOW       = '0
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_cg,
   input  logic [N_BUTTON-1:0] i_button,
   output logic [N_BUTTON-1:0] o_debounced,
   output logic [N_BUTTON-1:0] o_toggle,
   output logic [N_BUTTON-1:0] o_pressed,
   output logic [N_BUTTON-1:0] o_released,
   output logic [N_BUTTON-1:0] o_longpress
);

   // Reject parameter sets the channel logic cannot honour.
   if ((N_BUTTON < 1) || (N_BUTTON > 32)) begin : g_bad_n_button
      $error("pushbutton_bank: N_BUTTON must be 1..32");
   end
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("pushbutton_bank: DEBOUNCE_CYCLES must be >= 2");
   end
   if (LONGPRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_longpress
      $error("pushbutton_bank: LONGPRESS_CYCLES must exceed DEBOUNCE_CYCLES");
   end

   // One fully independent channel per button pin.
   for (genvar g = 0; g < N_BUTTON; g++) begin : g_chan
      pushbutton_channel #(
         .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
`ifdef PUSHBUTTON_BANK_LONGPRESS_EN
         .LONGPRESS_CYCLES (LONGPRESS_CYCLES),
`endif
         .INVERT           (ACTIVE_LOW[g])
      ) u_chan (
         .clk_i       (i_clk),
         .rst_ni      (i_rst_n),
         .cg_i        (i_cg),
         .button_i    (i_button[g]),
         .debounced_o (o_debounced[g]),
         .toggle_o    (o_toggle[g]),
         .pressed_o   (o_pressed[g]),
         .released_o  (o_released[g]),
         .longpress_o (o_longpress[g])
      );
   end

endmodule

// File: tb/tb_pushbutton_bank.sv
// Self-checking bench for pushbutton_bank (N_BUTTON=3, DEBOUNCE_CYCLES=4,
// LONGPRESS_CYCLES=10, ACTIVE_LOW=3'b100). Expected per-cycle output words
// {debounced, toggle, pressed, released, longpress} are queued as stimulus
// is planned and popped one per clock as the DUT runs.
module tb_pushbutton_bank;

   localparam int   N  = 3;
   localparam int   W  = 5 * N;
   localparam logic [N-1:0] AL = 3'b100;
   localparam logic [N-1:0] IDLE_PINS = 3'b100;

   logic         i_clk;
   logic         i_rst_n;
   logic         i_cg;
   logic [N-1:0] i_button;
   logic [N-1:0] o_debounced, o_toggle, o_pressed, o_released, o_longpress;

   pushbutton_bank #(
      .N_BUTTON         (N),
      .DEBOUNCE_CYCLES  (4),
      .LONGPRESS_CYCLES (10),
      .ACTIVE_LOW       (AL)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_cg        (i_cg),
      .i_button    (i_button),
      .o_debounced (o_debounced),
      .o_toggle    (o_toggle),
      .o_pressed   (o_pressed),
      .o_released  (o_released),
      .o_longpress (o_longpress)
   );

   // Clock and reset
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Scoreboard state
   logic [W-1:0] exp_q[$];
   logic [N-1:0] exp_deb;
   logic [N-1:0] exp_tog;
   logic         lp_seen;
   logic         lp_exp_seen;
   int           checks;
   int           errors;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] outs();
      return {o_debounced, o_toggle, o_pressed, o_released, o_longpress};
   endfunction

   // Queue n cycles with no events and the current expected levels.
   task automatic exp_quiet(input int n);
      repeat (n) exp_q.push_back({exp_deb, exp_tog, 3'b000, 3'b000, 3'b000});
   endtask

   // Queue one cycle carrying press/release/long-press events.
   task automatic exp_event(input logic [N-1:0] rise, input logic [N-1:0] fall,
                            input logic [N-1:0] lp);
      exp_deb = (exp_deb | rise) & ~fall;
      exp_tog = exp_tog ^ rise;
      if (lp != '0) lp_exp_seen = 1'b1;
      exp_q.push_back({exp_deb, exp_tog, rise, fall, lp});
   endtask

   // Driver: advance n clocks, comparing each against the queue head.
   task automatic run(input int n, input string tag);
      logic [W-1:0] e;
      repeat (n) begin
         @(posedge i_clk);
         #1;
         if (o_longpress != '0) lp_seen = 1'b1;
         if (exp_q.size() == 0) begin
            check({tag, "_underflow"}, 32'(outs()), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check(tag, 32'(outs()), 32'(e));
         end
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      exp_deb     = '0;
      exp_tog     = '0;
      lp_seen     = 1'b0;
      lp_exp_seen = 1'b0;
      i_rst_n     = 1'b0;
      i_cg        = 1'b1;
      i_button    = IDLE_PINS;

      // Reset state
      repeat (3) begin
         @(posedge i_clk);
         #1;
         check("reset", 32'(outs()), 32'd0);
      end
      i_rst_n = 1'b1;

      // Clean press on channel 0, held long enough for a long press
      i_button = 3'b101;
      exp_quiet(5);
      exp_event(3'b001, 3'b000, 3'b000);
`ifdef PUSHBUTTON_BANK_LONGPRESS_EN
      exp_quiet(9);
      exp_event(3'b000, 3'b000, 3'b001);
`else
      exp_quiet(10);
`endif
      exp_quiet(2);
      run(18, "press0");
      i_button = IDLE_PINS;
      exp_quiet(5);
      exp_event(3'b000, 3'b001, 3'b000);
      exp_quiet(2);
      run(8, "release0");

      // Glitch on channel 1 one cycle short of acceptance
      i_button = 3'b110;
      exp_quiet(11);
      run(3, "glitch1");
      i_button = IDLE_PINS;
      run(8, "glitch1");

      // Pulse of exactly DEBOUNCE_CYCLES on channel 1 is accepted
      i_button = 3'b110;
      exp_quiet(5);
      exp_event(3'b010, 3'b000, 3'b000);
      exp_quiet(3);
      exp_event(3'b000, 3'b010, 3'b000);
      exp_quiet(2);
      run(4, "exact1");
      i_button = IDLE_PINS;
      run(8, "exact1");

      // Active-low channel 2
      i_button = 3'b000;
      exp_quiet(5);
      exp_event(3'b100, 3'b000, 3'b000);
      exp_quiet(2);
      run(8, "actlow_press");
      i_button = IDLE_PINS;
      exp_quiet(5);
      exp_event(3'b000, 3'b100, 3'b000);
      exp_quiet(2);
      run(8, "actlow_release");

      // Clock gate low for 5 cycles mid-debounce delays acceptance by 5
      i_button = 3'b101;
      exp_quiet(10);
      exp_event(3'b001, 3'b000, 3'b000);
      exp_quiet(2);
      run(3, "cg_press");
      i_cg = 1'b0;
      run(5, "cg_gated");
      i_cg = 1'b1;
      run(5, "cg_press");
      i_button = IDLE_PINS;
      exp_quiet(5);
      exp_event(3'b000, 3'b001, 3'b000);
      exp_quiet(1);
      run(7, "cg_release");

      // Reset in the middle of a hold, button kept pressed
      i_button = 3'b101;
      exp_quiet(5);
      exp_event(3'b001, 3'b000, 3'b000);
      exp_quiet(6);
      run(12, "hold_pre_rst");
      #2;
      i_rst_n = 1'b0;
      #1;
      check("rst_async", 32'(outs()), 32'd0);
      exp_deb = '0;
      exp_tog = '0;
      repeat (2) begin
         @(posedge i_clk);
         #1;
         if (o_longpress != '0) lp_seen = 1'b1;
         check("rst_hold", 32'(outs()), 32'd0);
      end
      i_rst_n = 1'b1;
      exp_quiet(5);
      exp_event(3'b001, 3'b000, 3'b000);
      exp_quiet(2);
      run(8, "rst_repress");
      i_button = IDLE_PINS;
      exp_quiet(5);
      exp_event(3'b000, 3'b001, 3'b000);
      exp_quiet(1);
      run(7, "rst_release");

      // All three channels pressed and released together
      i_button = 3'b011;
      exp_quiet(5);
      exp_event(3'b111, 3'b000, 3'b000);
      exp_quiet(2);
      run(8, "simul_press");
      i_button = IDLE_PINS;
      exp_quiet(5);
      exp_event(3'b000, 3'b111, 3'b000);
      exp_quiet(2);
      run(8, "simul_release");

      // Run-wide bookkeeping
      check("longpress_seen", 32'(lp_seen), 32'(lp_exp_seen));
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
